// File: rtl/sram_parity_pkg.sv
// Shared types and parity helpers for the byte-masked 32x9-bit-lane SRAM port.
package sram_parity_pkg;

  localparam int LANES  = 32;
  localparam int LANE_W = 9;
  localparam int BYTE_W = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = LANES * BYTE_W;
  localparam int SRAM_W = LANES * LANE_W;

  // One read response as held in the response FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [LANES-1:0]  perr;
    logic [ADDR_W-1:0] addr;
  } rsp_entry_t;

  // Spread bytes into 9-bit lanes and add even parity in bit 8,
  // optionally inverted per lane to plant errors.
  function automatic logic [SRAM_W-1:0] gen_parity(input logic [DATA_W-1:0] data,
                                                   input logic [LANES-1:0]  inject);
    logic [SRAM_W-1:0] word;
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      word[i*LANE_W +: BYTE_W]  = data[i*BYTE_W +: BYTE_W];
      word[i*LANE_W + BYTE_W]   = (^data[i*BYTE_W +: BYTE_W]) ^ inject[i];
    end
    return word;
  endfunction

  // A lane is in error when its 9 bits have odd parity.
  function automatic logic [LANES-1:0] check_parity(input logic [SRAM_W-1:0] word);
    logic [LANES-1:0] perr;
    perr = '0;
    for (int i = 0; i < LANES; i++) begin
      perr[i] = ^word[i*LANE_W +: LANE_W];
    end
    return perr;
  endfunction

  // Drop the parity bit of every lane.
  function automatic logic [DATA_W-1:0] strip_parity(input logic [SRAM_W-1:0] word);
    logic [DATA_W-1:0] data;
    data = '0;
    for (int i = 0; i < LANES; i++) begin
      data[i*BYTE_W +: BYTE_W] = word[i*LANE_W +: BYTE_W];
    end
    return data;
  endfunction

endpackage

// File: rtl/sram_parity_rsp_fifo.sv
// Circular response FIFO; head entry is presented combinationally and reads as zero when empty.
module sram_parity_rsp_fifo
  import sram_parity_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  rsp_entry_t       push_entry,
  input  logic             pop,
  output logic             out_valid,
  output rsp_entry_t       out_entry,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents only matter once the count covers them.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign out_valid = (count_q != '0);
  assign out_entry = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/sram_parity_port.sv
// Request-side SRAM controller: parity generation on writes, parity checking and
// ordered, backpressurable responses on reads, plus a sticky error log.
module sram_parity_port
  import sram_parity_pkg::*;
#(
  parameter int RSP_DEPTH = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [LANES-1:0]     req_wmask,
  input  logic [LANES-1:0]     req_perr_inject,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [LANES-1:0]     rsp_perr,
  output logic                 rsp_err,
  output logic                 sram_valid,
  output logic                 sram_write,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [SRAM_W-1:0]    sram_wdata,
  output logic [LANES-1:0]     sram_wmask,
  input  logic [SRAM_W-1:0]    sram_rdata,
  input  logic                 volt_sel,
  output logic                 sram_volt_sel,
  input  logic                 err_clear,
  output logic                 err_valid,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic                 rd_inflight_q, rd_inflight_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                 err_valid_q, err_valid_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       occupancy;
  logic                 rd_room;
  logic                 accept;
  logic                 push, pop;
  rsp_entry_t           push_entry, head_entry;
  logic                 unused_head_addr;

  // Reads reserve a FIFO slot at accept time so a captured response always fits;
  // only registered state feeds this, never rsp_ready.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight_q};
  assign rd_room   = occupancy < (CNT_W + 1)'(RSP_DEPTH);
  assign req_ready = req_write | rd_room;
  assign accept    = req_valid & req_ready;

  assign sram_volt_sel = volt_sel;

  // Drive the SRAM in the accept cycle; idle fields are held at zero.
  always_comb begin
    sram_valid = accept;
    sram_write = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (accept) begin
      sram_addr = req_addr;
      if (req_write) begin
        sram_write = 1'b1;
        sram_wdata = gen_parity(req_wdata, req_perr_inject);
        sram_wmask = req_wmask;
      end
    end
  end

  // Track the single outstanding read whose data arrives next cycle.
  always_comb begin
    rd_inflight_d = accept & ~req_write;
    rd_addr_d     = rd_addr_q;
    if (accept && !req_write) rd_addr_d = req_addr;
  end

  // Read pipeline registers; an in-flight read is dropped by reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_inflight_q <= 1'b0;
      rd_addr_q     <= '0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      rd_addr_q     <= rd_addr_d;
    end
  end

  assign push             = rd_inflight_q;
  assign push_entry.rdata = strip_parity(sram_rdata);
  assign push_entry.perr  = check_parity(sram_rdata);
  assign push_entry.addr  = rd_addr_q;
  assign pop              = rsp_valid & rsp_ready;

  sram_parity_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .out_valid  (rsp_valid),
    .out_entry  (head_entry),
    .count      (fifo_count)
  );

  assign rsp_rdata        = head_entry.rdata;
  assign rsp_perr         = head_entry.perr;
  assign rsp_err          = |head_entry.perr;
  assign unused_head_addr = ^head_entry.addr;

  // Error log: a clear wins over an error arriving in the same cycle.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (err_clear) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end else if (push && (push_entry.perr != '0)) begin
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        err_addr_d  = rd_addr_q;
      end
    end
  end

  // Error log registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sram_parity_port.sv
// Directed bench for sram_parity_port with a behavioural one-cycle-latency SRAM.
module tb_sram_parity_port;

  logic         clock;
  logic         resetn;
  logic         req_valid, req_ready, req_write;
  logic [7:0]   req_addr;
  logic [255:0] req_wdata;
  logic [31:0]  req_wmask, req_perr_inject;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [255:0] rsp_rdata;
  logic [31:0]  rsp_perr;
  logic         sram_valid, sram_write;
  logic [7:0]   sram_addr;
  logic [287:0] sram_wdata, sram_rdata;
  logic [31:0]  sram_wmask;
  logic         volt_sel, sram_volt_sel;
  logic         err_clear, err_valid;
  logic [7:0]   err_addr;
  logic [1:0]   err_count;

  int tests_run;
  int tests_failed;

  logic [287:0] sram_mem [256];
  logic [255:0] exp_data [256];
  logic [31:0]  exp_perr [256];

  sram_parity_port #(
    .RSP_DEPTH (4),
    .ERR_CNT_W (2)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wmask       (req_wmask),
    .req_perr_inject (req_perr_inject),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_perr        (rsp_perr),
    .rsp_err         (rsp_err),
    .sram_valid      (sram_valid),
    .sram_write      (sram_write),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_wmask      (sram_wmask),
    .sram_rdata      (sram_rdata),
    .volt_sel        (volt_sel),
    .sram_volt_sel   (sram_volt_sel),
    .err_clear       (err_clear),
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .err_count       (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM: byte-masked lane writes, registered read data.
  always @(posedge clock) begin
    if (sram_valid) begin
      if (sram_write) begin
        for (int i = 0; i < 32; i++)
          if (sram_wmask[i]) sram_mem[sram_addr][i*9 +: 9] <= sram_wdata[i*9 +: 9];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  function automatic logic [255:0] rep_byte(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_addr        = '0;
    req_wdata       = '0;
    req_wmask       = '0;
    req_perr_inject = '0;
  endtask

  task automatic shadow_write(input logic [7:0] a, input logic [255:0] d,
                              input logic [31:0] m, input logic [31:0] inj);
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        exp_data[a][i*8 +: 8] = d[i*8 +: 8];
        exp_perr[a][i]        = inj[i];
      end
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [255:0] d,
                          input logic [31:0] m, input logic [31:0] inj);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a;
    req_wdata = d; req_wmask = m; req_perr_inject = inj;
    shadow_write(a, d, m, inj);
    $display("[TB] WR addr=%02h mask=%08h inj=%08h", a, m, inj);
    step();
    drive_idle();
  endtask

  // Leaves the caller in cycle N+1 of the read.
  task automatic do_read(input logic [7:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    $display("[TB] RD addr=%02h", a);
    step();
    drive_idle();
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic pop_rsp();
    $display("[TB] RSP rdata[31:0]=%08h perr=%08h", rsp_rdata[31:0], rsp_perr);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    tests_run++;
    if (err_valid !== 1'b0 || err_addr !== 8'h00 || err_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_err_log got v=%0b a=%02h c=%0d want 0/00/0", err_valid, err_addr, err_count);
    end
    tests_run++;
    if (rsp_rdata !== '0 || rsp_perr !== '0) begin
      tests_failed++; $display("FAIL reset_rsp_data got %h/%h want 0", rsp_rdata, rsp_perr);
    end
    tests_run++;
    volt_sel = 1'b1; #1;
    if (sram_volt_sel !== 1'b1) begin tests_failed++; $display("FAIL volt_sel got %0b want 1", sram_volt_sel); end
    volt_sel = 1'b0;
    $display("[TB] reset checks done");
  endtask

  task automatic test_write_read();
    logic [287:0] exp_w;
    bit ok;
    exp_w = {32{9'h101}};
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10;
    req_wdata = rep_byte(8'h01); req_wmask = '1; req_perr_inject = '0;
    #1;
    tests_run++;
    if (sram_valid !== 1'b1 || sram_write !== 1'b1 || sram_addr !== 8'h10) begin
      tests_failed++; $display("FAIL wr_ctrl got v=%0b w=%0b a=%02h want 1/1/10", sram_valid, sram_write, sram_addr);
    end
    tests_run++;
    if (sram_wdata !== exp_w || sram_wmask !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL wr_wdata got %h mask %h want %h", sram_wdata, sram_wmask, exp_w);
    end
    shadow_write(8'h10, rep_byte(8'h01), '1, '0);
    $display("[TB] WR addr=10 data=01..01");
    step();
    drive_idle();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    #1;
    tests_run++;
    if (sram_valid !== 1'b1 || sram_write !== 1'b0 || sram_wmask !== '0 || sram_wdata !== '0) begin
      tests_failed++; $display("FAIL rd_ctrl got v=%0b w=%0b m=%h want 1/0/0", sram_valid, sram_write, sram_wmask);
    end
    $display("[TB] RD addr=10");
    step();
    drive_idle();
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_latency_n1 got rsp_valid=%0b want 0", rsp_valid); end
    step();
    tests_run++;
    if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL rd_latency_n2 got rsp_valid=%0b want 1", rsp_valid); end
    tests_run++;
    if (rsp_rdata !== rep_byte(8'h01) || rsp_perr !== '0 || rsp_err !== 1'b0) begin
      tests_failed++; $display("FAIL rd_data got %h perr %h err %0b want 01.. / 0 / 0", rsp_rdata, rsp_perr, rsp_err);
    end
    wait_rsp(ok);
    pop_rsp();
  endtask

  task automatic test_parity_error();
    bit ok;
    do_write(8'h20, '0, '1, 32'h0000_0005);
    do_read(8'h20);
    wait_rsp(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL perr_timeout got no response want one"); end
    tests_run++;
    if (rsp_perr !== 32'h5 || rsp_err !== 1'b1) begin
      tests_failed++; $display("FAIL perr_flags got %h err %0b want 00000005 1", rsp_perr, rsp_err);
    end
    tests_run++;
    if (err_valid !== 1'b1 || err_addr !== 8'h20 || err_count !== 2'd1) begin
      tests_failed++; $display("FAIL perr_log1 got v=%0b a=%02h c=%0d want 1/20/1", err_valid, err_addr, err_count);
    end
    pop_rsp();
    do_write(8'h30, rep_byte(8'h55), '1, 32'h8000_0000);
    do_read(8'h30);
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_perr !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL perr_lane31 got ok=%0b perr %h want 80000000", ok, rsp_perr);
    end
    tests_run++;
    if (err_addr !== 8'h20 || err_count !== 2'd2) begin
      tests_failed++; $display("FAIL perr_log2 got a=%02h c=%0d want 20/2", err_addr, err_count);
    end
    pop_rsp();
  endtask

  task automatic test_saturate_clear();
    bit ok;
    do_write(8'h50, rep_byte(8'h07), '1, 32'h0000_0001);
    do_read(8'h50);
    wait_rsp(ok);
    tests_run++;
    if (!ok || err_count !== 2'd3) begin tests_failed++; $display("FAIL sat_reach got c=%0d want 3", err_count); end
    pop_rsp();
    do_read(8'h50);
    wait_rsp(ok);
    tests_run++;
    if (!ok || err_count !== 2'd3) begin tests_failed++; $display("FAIL sat_hold got c=%0d want 3", err_count); end
    pop_rsp();
    do_read(8'h50);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    tests_run++;
    if (err_count !== 2'd0 || err_valid !== 1'b0 || err_addr !== 8'h00) begin
      tests_failed++; $display("FAIL clear_prio got v=%0b a=%02h c=%0d want 0/00/0", err_valid, err_addr, err_count);
    end
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_perr !== 32'h1) begin
      tests_failed++; $display("FAIL clear_rsp got v=%0b perr %h want 1/00000001", rsp_valid, rsp_perr);
    end
    pop_rsp();
  endtask

  task automatic test_backpressure();
    int accepted;
    for (int k = 0; k < 4; k++) do_write(8'h60 + 8'(k), rep_byte(8'hA0 + 8'(k)), '1, '0);
    rsp_ready = 1'b0;
    accepted  = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h60;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready === 1'b1) begin
        $display("[TB] RD addr=%02h accepted", req_addr);
        accepted++;
      end
      step();
      req_addr = 8'h60 + 8'(accepted);
    end
    req_valid = 1'b0;
    #1;
    tests_run++;
    if (accepted != 4) begin tests_failed++; $display("FAIL bp_accepts got %0d want 4", accepted); end
    tests_run++;
    if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_rd_ready got %0b want 0", req_ready); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h70;
    req_wdata = rep_byte(8'h77); req_wmask = '1; req_perr_inject = '0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || sram_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_write_ok got ready=%0b sram_valid=%0b want 1/1", req_ready, sram_valid);
    end
    shadow_write(8'h70, rep_byte(8'h77), '1, '0);
    $display("[TB] WR addr=70 during stall");
    step();
    drive_idle();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== rep_byte(8'hA0)) begin
      tests_failed++; $display("FAIL bp_head got v=%0b %h want 1/a0..", rsp_valid, rsp_rdata[31:0]);
    end
    step();
    step();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== rep_byte(8'hA0)) begin
      tests_failed++; $display("FAIL bp_stable got v=%0b %h want 1/a0..", rsp_valid, rsp_rdata[31:0]);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rep_byte(8'hA0 + 8'(k))) begin
        tests_failed++; $display("FAIL bp_order%0d got v=%0b %h want a%0h", k, rsp_valid, rsp_rdata[31:0], k);
      end
      $display("[TB] RSP %0d rdata[7:0]=%02h", k, rsp_rdata[7:0]);
      step();
    end
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain got v=%0b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int issued, rcv, stalls;
    issued = 0; rcv = 0; stalls = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 400 && rcv < 256; c++) begin
      if (issued < 256) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(issued);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (rsp_valid === 1'b1) begin
        tests_run++;
        if (rsp_rdata !== exp_data[rcv] || rsp_perr !== exp_perr[rcv]) begin
          tests_failed++;
          $display("FAIL stream_rsp%0d got %h/%h want %h/%h", rcv, rsp_rdata[31:0], rsp_perr,
                   exp_data[rcv][31:0], exp_perr[rcv]);
        end
        $display("[TB] RSP addr=%02h rdata[7:0]=%02h", rcv, rsp_rdata[7:0]);
        rcv++;
      end
      if (issued < 256) begin
        if (req_ready === 1'b1) issued++;
        else stalls++;
      end
      step();
    end
    drive_idle();
    rsp_ready = 1'b0;
    tests_run++;
    if (rcv != 256 || stalls != 0) begin
      tests_failed++; $display("FAIL stream_count got rcv=%0d stalls=%0d want 256/0", rcv, stalls);
    end
  endtask

  task automatic test_read_then_write();
    bit ok;
    do_write(8'h40, rep_byte(8'h3C), '1, '0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
    $display("[TB] RD addr=40");
    step();
    req_write = 1'b1; req_wdata = rep_byte(8'hC3); req_wmask = '1;
    $display("[TB] WR addr=40 right behind read");
    step();
    drive_idle();
    shadow_write(8'h40, rep_byte(8'hC3), '1, '0);
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_rdata !== rep_byte(8'h3C)) begin
      tests_failed++; $display("FAIL raw_old got %h want 3c..", rsp_rdata[31:0]);
    end
    pop_rsp();
    do_read(8'h40);
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_rdata !== rep_byte(8'hC3)) begin
      tests_failed++; $display("FAIL raw_new got %h want c3..", rsp_rdata[31:0]);
    end
    pop_rsp();
  endtask

  task automatic test_partial_mask();
    bit ok;
    // Only lanes 0 and 31 change; the rest keep 0x01 from the first write.
    do_write(8'h10, rep_byte(8'hFF), 32'h8000_0001, '0);
    do_write(8'h10, rep_byte(8'h99), 32'h0, '0);
    do_read(8'h10);
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_rdata !== {8'hFF, {30{8'h01}}, 8'hFF} || rsp_perr !== '0) begin
      tests_failed++; $display("FAIL partial_mask got %h perr %h", rsp_rdata, rsp_perr);
    end
    pop_rsp();
  endtask

  task automatic test_reset_inflight();
    int seen;
    seen = 0;
    do_read(8'h10);
    #1;
    resetn = 1'b0;
    $display("[TB] reset asserted with read in flight");
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rsp_valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL reset_drop got %0d valid cycles want 0", seen); end
    tests_run++;
    if (req_ready !== 1'b1 || err_count !== 2'd0 || err_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state got ready=%0b c=%0d v=%0b want 1/0/0", req_ready, err_count, err_valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int a = 0; a < 256; a++) begin
      sram_mem[a] = '0;
      exp_data[a] = '0;
      exp_perr[a] = '0;
    end
    sram_rdata = '0;
    drive_idle();
    rsp_ready = 1'b0;
    volt_sel  = 1'b0;
    err_clear = 1'b0;
    resetn    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    step();

    test_reset();
    test_write_read();
    test_parity_error();
    test_saturate_clear();
    test_backpressure();
    test_read_then_write();
    test_partial_mask();
    test_back_to_back();
    test_reset_inflight();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_parity_port.md
Name: sram_parity_port

Overview:
Request-side controller for the 256x288 byte-masked SRAM (32 lanes x 9 bits). Accepts 256-bit word requests over valid/ready and generates an even-parity bit per byte into lane bit 8 on writes. On reads it captures the SRAM's one-cycle-latency rdata, checks parity per lane, and returns data plus error flags through a backpressurable response FIFO. Keeps a sticky first-error address and a saturating error counter for diagnostics.

Parameters:
RSP_DEPTH, 4, response FIFO entries; legal 2..16; values >=3 give one read per cycle under continuous rsp_ready
ERR_CNT_W, 16, width of saturating parity-error counter

Ports:
clock  input  1  sole clock
resetn  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  8  word address
req_wdata  input  256  write data, byte i = [i*8 +: 8]
req_wmask  input  32  per-byte write enable
req_perr_inject  input  32  per-lane parity inversion on write (test hook)
rsp_valid  output  1  read response valid
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  256  read data, parity stripped
rsp_perr  output  32  per-lane parity error
rsp_err  output  1  OR of rsp_perr
sram_valid  output  1  to SRAM valid
sram_write  output  1  to SRAM write
sram_addr  output  8  to SRAM addr
sram_wdata  output  288  to SRAM wdata
sram_wmask  output  32  to SRAM wmask
sram_rdata  input  288  from SRAM rdata
volt_sel  input  1  voltage select, forwarded
sram_volt_sel  output  1  = volt_sel, combinational
err_clear  input  1  synchronous clear of err_valid, err_addr, err_count
err_valid  output  1  sticky: a read with rsp_err has been captured
err_addr  output  8  address of first errored read since last clear
err_count  output  ERR_CNT_W  saturating count of errored reads

Behaviour:
- Lane map: lane i = sram bits [i*9 +: 9]; [i*9 +: 8] = byte i; bit i*9+8 = ^byte_i ^ req_perr_inject[i].
- Writes: req_ready = 1 always; no response produced. sram_* driven combinationally in the accept cycle. wmask = 0 is accepted as a no-op.
- Reads: req_ready = (fifo_count + rd_inflight) < RSP_DEPTH, with no combinational path from rsp_ready. sram_wmask = 0 on reads.
- sram_valid = req_valid & req_ready; when 0, sram_write/addr/wdata/wmask are don't-care but driven to 0.
- Read accepted in cycle N: rd_inflight set and address stored. At the end of N+1, sram_rdata is captured, checked, and pushed. rsp_valid is at the earliest in N+2.
- Check: perr[i] = ^sram_rdata[i*9 +: 9]. Data and perr are stored in the FIFO entry. Responses are in request order.
- A write accepted in N+1 to the same address does not affect the captured data (old value returned).
- FIFO: circular, wrap-around pointers. Push and pop in the same cycle when full are legal (count unchanged). rsp_* hold stable while rsp_valid & !rsp_ready.
- Error log, updated on push with perr != 0:
  - err_count increments and saturates at all-ones.
  - If !err_valid, err_addr <= read address and err_valid <= 1.
  - err_clear has priority over a same-cycle update: a cleared value is applied and the update is dropped.
- Reset values: rsp_valid 0, FIFO empty, rd_inflight 0, err_valid 0, err_addr 0, err_count 0, rsp_rdata/rsp_perr 0. An in-flight read at reset is discarded. After reset, req_ready = 1.

Decomposition:
- Shared package sram_parity_pkg:
  - LANES = 32, LANE_W = 9, BYTE_W = 8, ADDR_W = 8
  - rsp_entry_t {rdata[255:0], perr[31:0], addr[7:0]}
  - functions gen_parity and check_parity
- One sub-module: sram_parity_rsp_fifo (parameterized depth, rsp_entry_t payload, count output).

Test Plan:
- Write addr 0x10, wdata all 0x01, wmask all-ones -> sram_wdata lane i = 9'h101 for all i. Read 0x10 -> rsp_rdata all 0x01, rsp_perr 0, rsp_valid in cycle N+2.
- Write 0x20 with perr_inject = 0x0000_0005, then read 0x20 -> rsp_perr 0x5, rsp_err 1, err_valid 1, err_addr 0x20, err_count 1. A second errored read of 0x30 keeps err_addr 0x20 and sets err_count 2.
- Hold rsp_ready = 0 and issue reads each cycle -> exactly RSP_DEPTH (4) accepted, then req_ready 0 while writes are still accepted. Release rsp_ready -> 4 responses in order with stable data during stall.
- Continuous reads of addrs 0..255 with rsp_ready = 1 -> one accept per cycle, 256 responses in order.
- Read 0x40 in N and write 0x40 in N+1 -> response carries the pre-write data.
- Force err_count to saturate (ERR_CNT_W = 2 build) -> count holds at 3. err_clear coincident with an errored push -> count 0, err_valid 0. Assert resetn low with a read in flight -> no response after release.
